// File: rtl/alu_result_stage_if.sv
// Handshake bundle between the ALU, the result stage and writeback.
// Upstream payload plus downstream FIFO head, with master/slave views.
interface alu_result_stage_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [2:0]       in_m;
   logic [WIDTH-1:0] in_y;
   logic             in_zf;
   logic             in_cf;
   logic             in_of;
   logic             in_set_flags;
   logic [2:0]       in_cond;
   logic [4:0]       in_tag;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_y;
   logic [4:0]       out_tag;
   logic             out_cond_true;
   logic             out_illegal;

   modport master (
      output in_valid, in_m, in_y, in_zf, in_cf, in_of,
      output in_set_flags, in_cond, in_tag, out_ready,
      input  in_ready, out_valid, out_y, out_tag,
      input  out_cond_true, out_illegal
   );

   modport slave (
      input  in_valid, in_m, in_y, in_zf, in_cf, in_of,
      input  in_set_flags, in_cond, in_tag, out_ready,
      output in_ready, out_valid, out_y, out_tag,
      output out_cond_true, out_illegal
   );
endinterface

// File: rtl/alu_result_stage.sv
// Execute back end: flag register, condition evaluation and a
// small result FIFO toward writeback.
module alu_result_stage #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   alu_result_stage_if.slave        bus,
   output logic [3:0]               flags_q,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   logic [WIDTH-1:0] y_q   [DEPTH];
   logic [4:0]       tag_q [DEPTH];
   logic             ct_q  [DEPTH];
   logic             ill_q [DEPTH];

   logic [AW-1:0] wr_q, wr_d;
   logic [AW-1:0] rd_q, rd_d;
   logic [CW-1:0] count_q, count_d;
   logic [3:0]    flags_d;

   logic       in_rdy;
   logic       push;
   logic       pop;
   logic       legal;
   logic       arith;
   logic [3:0] cap;
   logic [3:0] src;
   logic       eval;
   logic       cond_true;

   assign in_rdy       = (count_q != FULL) && !rst;
   assign push         = bus.in_valid & in_rdy;
   assign pop          = (count_q != '0) & bus.out_ready;

   assign bus.in_ready      = in_rdy;
   assign bus.out_valid     = (count_q != '0);
   assign bus.out_y         = y_q[rd_q];
   assign bus.out_tag       = tag_q[rd_q];
   assign bus.out_cond_true = ct_q[rd_q];
   assign bus.out_illegal   = ill_q[rd_q];
   assign count             = count_q;

   // Capture flags from the ALU and evaluate the requested condition.
   always_comb begin
      legal = (bus.in_m <= 3'd4);
      arith = (bus.in_m == 3'd0) || (bus.in_m == 3'd1);
      cap   = {bus.in_y[WIDTH-1], bus.in_zf,
               arith & bus.in_cf, arith & bus.in_of};
      src   = bus.in_set_flags ? cap : flags_q;
      eval  = 1'b0;
      unique case (bus.in_cond)
         3'd0: eval = 1'b1;
         3'd1: eval = src[2];
         3'd2: eval = !src[2];
         3'd3: eval = src[1];
         3'd4: eval = !src[1];
         3'd5: eval = src[3] ^ src[0];
         3'd6: eval = !(src[3] ^ src[0]);
         3'd7: eval = 1'b0;
         default: eval = 1'b0;
      endcase
      cond_true = legal & eval;
   end

   // Pointer, occupancy and flag next-state.
   always_comb begin
      wr_d    = wr_q;
      rd_d    = rd_q;
      count_d = count_q;
      flags_d = flags_q;
      if (push) wr_d = wr_q + 1'b1;
      if (pop)  rd_d = rd_q + 1'b1;
      unique case (1'b1)
         push && !pop: count_d = count_q + 1'b1;
         pop && !push: count_d = count_q - 1'b1;
         default:      count_d = count_q;
      endcase
      if (push && bus.in_set_flags && legal) flags_d = cap;
   end

   // State registers and FIFO storage; storage written only on push.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_q    <= '0;
         rd_q    <= '0;
         count_q <= '0;
         flags_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            y_q[i]   <= '0;
            tag_q[i] <= '0;
            ct_q[i]  <= 1'b0;
            ill_q[i] <= 1'b0;
         end
      end else begin
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         count_q <= count_d;
         flags_q <= flags_d;
         if (push) begin
            y_q[wr_q]   <= bus.in_y;
            tag_q[wr_q] <= bus.in_tag;
            ct_q[wr_q]  <= cond_true;
            ill_q[wr_q] <= !legal;
         end
      end
   end
endmodule
